// File: rtl/axis_frame_pkg.sv
// Shared definitions for the AXI-Stream frame engine: FSM states, status word
// layout and a constant-friendly clog2.
package axis_frame_pkg;

  typedef enum logic [2:0] {
    ST_RECV,
    ST_DRAIN,
    ST_START,
    ST_WAIT,
    ST_SEND
  } state_t;

  localparam int STAT_OVF   = 31;
  localparam int STAT_SHORT = 30;
  localparam int STAT_CNT_W = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/axis_frame_tx.sv
// Output side of the frame engine: captures the core result, then streams the
// result words and the optional status word with registered tdata/tlast.
module axis_frame_tx
  import axis_frame_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_WORDS   = 8,
  parameter int EMIT_STATUS = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_load,
  input  logic [OUT_WORDS*DATA_WIDTH-1:0] i_core_out,
  input  logic                            i_ovf,
  input  logic                            i_short,
  input  logic [STAT_CNT_W-1:0]           i_rx_cnt,
  input  logic                            i_tready,
  output logic                            o_tvalid,
  output logic                            o_tlast,
  output logic                            o_done,
  output logic [DATA_WIDTH-1:0]           o_tdata
);

  localparam int TOTAL = OUT_WORDS + EMIT_STATUS;
  localparam int PTR_W = clog2(TOTAL + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(TOTAL - 1);

  logic [DATA_WIDTH-1:0] r_bank [OUT_WORDS];
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_nxt_word;
  logic [31:0]           w_stat32;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      w_nxt;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  w_fire;

  always_comb begin
    w_stat32                   = '0;
    w_stat32[STAT_OVF]         = i_ovf;
    w_stat32[STAT_SHORT]       = i_short;
    w_stat32[STAT_CNT_W-1:0]   = i_rx_cnt;
  end

  assign w_status = DATA_WIDTH'(w_stat32);

  // Word that follows the current one; indices past the result bank map to status.
  always_comb begin
    w_nxt      = r_rd_ptr + PTR_W'(1);
    w_nxt_word = w_status;
    for (int i = 0; i < OUT_WORDS; i++) begin
      if (w_nxt == PTR_W'(i)) w_nxt_word = r_bank[i];
    end
  end

  assign w_fire   = r_tvalid && i_tready;
  assign o_done   = w_fire && (r_rd_ptr == LAST_IDX);
  assign o_tvalid = r_tvalid;
  assign o_tlast  = r_tlast;
  assign o_tdata  = r_tdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < OUT_WORDS; i++) r_bank[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < OUT_WORDS; i++) r_bank[i] <= i_core_out[i*DATA_WIDTH +: DATA_WIDTH];
      r_tvalid <= 1'b1;
      r_tdata  <= i_core_out[DATA_WIDTH-1:0];
      r_tlast  <= (LAST_IDX == '0);
      r_rd_ptr <= '0;
    end else if (w_fire) begin
      if (r_rd_ptr == LAST_IDX) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        r_tdata  <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_rd_ptr <= w_nxt;
        r_tdata  <= w_nxt_word;
        r_tlast  <= (w_nxt == LAST_IDX);
      end
    end
  end

endmodule

// File: rtl/axis_frame_engine.sv
// AXI-Stream front end for a fixed-function core: buffers one input frame,
// pulses core_start, and hands the core result to the streaming transmitter.
module axis_frame_engine
  import axis_frame_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IN_WORDS    = 20,
  parameter int OUT_WORDS   = 8,
  parameter int EMIT_STATUS = 1
) (
  input  logic                              axis_aclk,
  input  logic                              axis_aresetn,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic                              s_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0]           m_axis_tstrb,
  output logic                              core_start,
  output logic [IN_WORDS*DATA_WIDTH-1:0]    core_in,
  output logic [clog2(IN_WORDS+1)-1:0]      core_in_len,
  input  logic                              core_done,
  input  logic [OUT_WORDS*DATA_WIDTH-1:0]   core_out
);

  localparam int LEN_W = clog2(IN_WORDS + 1);
  localparam logic [LEN_W-1:0]      LAST_WR  = LEN_W'(IN_WORDS - 1);
  localparam logic [LEN_W-1:0]      FULL_LEN = LEN_W'(IN_WORDS);
  localparam logic [STAT_CNT_W-1:0] CNT_MAX  = '1;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_buf [IN_WORDS];
  logic [LEN_W-1:0]      r_wr_ptr;
  logic [LEN_W-1:0]      w_len;
  logic [STAT_CNT_W-1:0] r_rx_cnt;
  logic                  r_ovf;
  logic                  r_short;
  logic                  w_tready;
  logic                  w_start;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_tx_done;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) r_state <= ST_RECV;
    else               r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_tready = 1'b0;
    w_start  = 1'b0;
    w_load   = 1'b0;
    case (r_state)
      ST_RECV: begin
        w_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tlast)             w_next = ST_START;
          else if (r_wr_ptr == LAST_WR) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) w_next = ST_START;
      end
      ST_START: begin
        w_start = 1'b1;
        w_next  = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          w_load = 1'b1;
          w_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_tx_done) w_next = ST_RECV;
      end
      default: w_next = ST_RECV;
    endcase
  end

  assign w_accept = w_tready && s_axis_tvalid;

  // In RECV the write pointer equals the beat count, so the tlast beat is short
  // exactly when it lands before the final buffer slot.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_wr_ptr <= '0;
      r_rx_cnt <= '0;
      r_ovf    <= 1'b0;
      r_short  <= 1'b0;
    end else if (r_state == ST_SEND && w_tx_done) begin
      r_wr_ptr <= '0;
      r_rx_cnt <= '0;
      r_ovf    <= 1'b0;
      r_short  <= 1'b0;
    end else if (w_accept) begin
      if (r_rx_cnt != CNT_MAX) r_rx_cnt <= r_rx_cnt + STAT_CNT_W'(1);
      if (r_state == ST_RECV) begin
        r_wr_ptr <= r_wr_ptr + LEN_W'(1);
        if (s_axis_tlast)             r_short <= (r_wr_ptr != LAST_WR);
        else if (r_wr_ptr == LAST_WR) r_ovf   <= 1'b1;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (r_state == ST_RECV && s_axis_tvalid) begin
      for (int i = 0; i < IN_WORDS; i++) begin
        if (r_wr_ptr == LEN_W'(i)) r_buf[i] <= s_axis_tdata;
      end
    end
  end

  assign w_len = (r_rx_cnt >= STAT_CNT_W'(IN_WORDS)) ? FULL_LEN : r_rx_cnt[LEN_W-1:0];

  // Stale buffer contents beyond the frame length are hidden rather than cleared.
  for (genvar gi = 0; gi < IN_WORDS; gi++) begin : g_core_in
    assign core_in[gi*DATA_WIDTH +: DATA_WIDTH] = (LEN_W'(gi) < w_len) ? r_buf[gi] : '0;
  end

  assign core_in_len   = w_len;
  assign core_start    = w_start;
  assign s_axis_tready = w_tready;
  assign m_axis_tstrb  = '1;

  axis_frame_tx #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OUT_WORDS   (OUT_WORDS),
    .EMIT_STATUS (EMIT_STATUS)
  ) u_tx (
    .i_clk      (axis_aclk),
    .i_rst_n    (axis_aresetn),
    .i_load     (w_load),
    .i_core_out (core_out),
    .i_ovf      (r_ovf),
    .i_short    (r_short),
    .i_rx_cnt   (r_rx_cnt),
    .i_tready   (m_axis_tready),
    .o_tvalid   (m_axis_tvalid),
    .o_tlast    (m_axis_tlast),
    .o_done     (w_tx_done),
    .o_tdata    (m_axis_tdata)
  );

endmodule

// File: doc/axis_frame_engine.md
# axis_frame_engine

Parametrised single-clock AXI-Stream front end for fixed-function compute cores such as the SHA-256 / bitcoin-miner datapath. It collects one input frame of up to IN_WORDS words into a register buffer, handles short and oversized frames, starts the attached core with a one-cycle pulse, and captures the core result. It then streams OUT_WORDS result words, plus an optional status word, on the master port with full backpressure support. It sits between the AXI DMA streams and the core, and replaces the earlier dual-clock-port wrapper.

## Interface
- DATA_WIDTH, 32: slave and master TDATA width; must be ≥32 when EMIT_STATUS=1.
- IN_WORDS, 20: input buffer depth, in words.
- OUT_WORDS, 8: result words per frame.
- EMIT_STATUS, 1: when 1, appends one status word after the result words.
- axis_aclk  in  1  sole clock.
- axis_aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  slave handshake.
- s_axis_tdata  in  DATA_WIDTH  input word.
- s_axis_tlast  in  1  end of input frame.
- m_axis_tvalid / m_axis_tready  out / in  1 / 1  master handshake.
- m_axis_tdata  out  DATA_WIDTH  output word.
- m_axis_tlast  out  1  marks the final output word.
- m_axis_tstrb  out  DATA_WIDTH/8  constant all-ones.
- core_start  out  1  one-cycle start pulse.
- core_in  out  IN_WORDS*DATA_WIDTH  word i is at [i*DATA_WIDTH +: DATA_WIDTH].
- core_in_len  out  clog2(IN_WORDS+1)  number of valid words, saturated at IN_WORDS.
- core_done  in  1  result valid; sampled only in WAIT.
- core_out  in  OUT_WORDS*DATA_WIDTH  result, same packing as core_in; valid only in the core_done cycle.

## Operation
- States: RECV (reset state), DRAIN, START, WAIT, SEND.
- RECV
  - s_axis_tready=1.
  - Each accepted beat is written to buf[wr_ptr] and increments wr_ptr and rx_cnt.
  - tlast → START.
  - Beat accepted at index IN_WORDS-1 without tlast → DRAIN, with the overflow flag set.
- DRAIN
  - s_axis_tready=1; beats are discarded but still counted in rx_cnt.
  - tlast → START.
- START: core_start=1 for exactly one cycle → WAIT.
- WAIT: on core_done, load core_out into the output register bank → SEND.
- SEND
  - s_axis_tready=0.
  - rd_ptr steps on each m_axis handshake.
  - Total words sent = OUT_WORDS+EMIT_STATUS.
  - Handshake on the last word → RECV; wr_ptr, rx_cnt and the flags are cleared.
- Zero-fill: core_in words with index ≥ core_in_len read as 0, masked combinationally. The buffer is not cleared.
- Short flag: set when tlast arrives with rx_cnt < IN_WORDS.
- Status word:
  - bit31 = overflow, bit30 = short.
  - [15:0] = rx_cnt, saturating at 16'hFFFF.
  - All other bits are 0.
- core_in and core_in_len hold stable from START until the return to RECV.
- core_done outside WAIT is ignored.

## Timing
- Reset values:
  - All state registers reset to RECV.
  - Outputs: s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, core_start=0.
  - Pointers, counters and flags are 0.
- Reset asserted mid-frame or mid-SEND clears all state immediately, asynchronously; the partial frame is lost. After deassertion the block is in RECV.
- Latency:
  - tlast accepted at cycle N → core_start at N+1.
  - core_done at M → m_axis_tvalid=1 with word 0 at M+1.
- m_axis_tdata and m_axis_tlast come from registers. They are held stable while tvalid && !tready.
- m_axis_tvalid stays high through SEND with no bubbles; throughput is one word per cycle when tready=1.
- m_axis_tlast is high only on word OUT_WORDS-1+EMIT_STATUS.
- Boundary cases:
  - tlast on exactly beat IN_WORDS → no overflow, no short, straight to START.
  - tlast on beat IN_WORDS+1 → overflow=1, rx_cnt=IN_WORDS+1.
  - A single-beat frame is legal: short=1, core_in_len=1.

## Structure
- Shared package axis_frame_pkg holds:
  - the state encoding constants;
  - status bit positions (STAT_OVF=31, STAT_SHORT=30, STAT_CNT_W=16);
  - the clog2 function.
- One sub-module: axis_frame_tx, containing the output register bank, rd_ptr, tvalid/tlast generation and status word mux. It has load and done handshakes to the parent FSM.

## Test plan
- Exact-length frame: 20 beats 0..19, tlast on beat 19 → core_start one cycle after; core_in_len=20; status word = 0x00000014.
- Short frame: 5 beats 0xA..0xE → core_in words 5..19 read 0; status = 0x40000005.
- Overflow frame: 23 beats with tlast on 23 → tready stays 1 throughout; core_in holds the first 20 beats; status = 0x80000017.
- Backpressure: core returns 0x100..0x107; tready toggles 1,0,0,1 repeatedly → 9 words in order; tdata stable during stalls; tlast only on the status word.
- Reset pulse at 3 cycles into SEND → tvalid=0 immediately; a following 20-word frame is processed normally.
- EMIT_STATUS=0, DATA_WIDTH=64, OUT_WORDS=4 → exactly 4 beats; tlast on beat 4; tstrb=0xFF.
